// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default widths for the fetch sequencer.
package fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PEND  = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ready bus between the fetch sequencer and imem.
interface fetch_sequencer_if #(
  parameter int INST_WIDTH = fetch_pkg::INST_WIDTH
) ();

  logic                  imem_req;
  logic                  imem_ready;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives PC enable/jump, the imem handshake, pipeline
// flushes, and a one-entry buffer for responses that land during a stall.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_BOOT  | post-reset idle, counting BOOT_CYCLES before the first fetch
// ST_FETCH | free to issue a request (or take a redirect) this cycle
// ST_WAIT  | request outstanding, memory has not answered yet
// ST_PEND  | request outstanding, but a redirect arrived; response is dropped
// ST_HOLD  | response captured in the buffer while the pipeline is stalled
module fetch_sequencer #(
  parameter int ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH,
  parameter int INST_WIDTH  = fetch_pkg::INST_WIDTH,
  parameter int BOOT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  fetch_sequencer_if.master     imem,
  output logic                  pc_en,
  output logic                  jump_en,
  output logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  fetch_valid,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  if_id_flush,
  output logic                  id_ex_flush
);

  import fetch_pkg::*;

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  fetch_state_e          state_q, state_d;
  logic [CNT_W-1:0]      boot_cnt_q, boot_cnt_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic [INST_WIDTH-1:0] buf_q, buf_d;
  logic                  req;

  assign imem.imem_req = req;

  // State, boot counter, latched redirect target and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      tgt_q      <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      tgt_q      <= tgt_d;
      buf_q      <= buf_d;
    end
  end

  // Next-state and Mealy outputs; redirect always outranks stall.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    tgt_d       = tgt_q;
    buf_d       = buf_q;
    req         = 1'b0;
    pc_en       = 1'b0;
    jump_en     = 1'b0;
    jump_target = '0;
    fetch_valid = 1'b0;
    inst_out    = '0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (redirect_valid) begin
          pc_en       = 1'b1;
          jump_en     = 1'b1;
          jump_target = redirect_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (!stall_req) begin
          req = 1'b1;
          if (imem.imem_ready) begin
            pc_en       = 1'b1;
            fetch_valid = 1'b1;
            inst_out    = imem.imem_rdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // An issued request stays up until memory answers.
        req = 1'b1;
        if (redirect_valid) begin
          tgt_d       = redirect_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (imem.imem_ready) begin
            pc_en       = 1'b1;
            jump_en     = 1'b1;
            jump_target = redirect_target;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_PEND;
          end
        end else if (imem.imem_ready) begin
          if (!stall_req) begin
            pc_en       = 1'b1;
            fetch_valid = 1'b1;
            inst_out    = imem.imem_rdata;
            state_d     = ST_FETCH;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end

      ST_PEND: begin
        req = 1'b1;
        if (redirect_valid) begin
          tgt_d       = redirect_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (imem.imem_ready) begin
          // Youngest redirect wins, including one arriving with the response.
          pc_en       = 1'b1;
          jump_en     = 1'b1;
          jump_target = redirect_valid ? redirect_target : tgt_q;
          if_id_flush = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_en       = 1'b1;
          jump_en     = 1'b1;
          jump_target = redirect_target;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          buf_d       = '0;
          state_d     = ST_FETCH;
        end else if (!stall_req) begin
          pc_en       = 1'b1;
          fetch_valid = 1'b1;
          inst_out    = buf_q;
          state_d     = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a transaction-level model predicts the
// outputs of each cycle, a negedge monitor pops and compares.
module tb_fetch_sequencer;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int BC = 2;

  typedef struct packed {
    logic          req;
    logic          pc_en;
    logic          jump_en;
    logic [AW-1:0] jt;
    logic          fv;
    logic [IW-1:0] inst;
    logic          ifid;
    logic          idex;
  } out_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_req = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          ready = 1'b0;
  logic [IW-1:0] rdata = '0;

  logic          pc_en, jump_en, fetch_valid, if_id_flush, id_ex_flush;
  logic [AW-1:0] jump_target;
  logic [IW-1:0] inst_out;

  fetch_sequencer_if #(.INST_WIDTH(IW)) imem ();
  assign imem.imem_ready = ready;
  assign imem.imem_rdata = rdata;

  fetch_sequencer #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .BOOT_CYCLES(BC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_req      (stall_req),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem           (imem),
    .pc_en          (pc_en),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .fetch_valid    (fetch_valid),
    .inst_out       (inst_out),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: what the fetch stage owes the pipeline, not how the RTL encodes it.
  int            boot_left   = BC;
  bit            outstanding = 0;   // a request is on the bus
  bit            pend        = 0;   // a redirect is waiting for that request to finish
  bit            held        = 0;   // an instruction is parked for a stalled pipeline
  logic [AW-1:0] ptgt        = '0;
  logic [IW-1:0] hval        = '0;

  task automatic step(input bit r, input bit st, input bit rv, input logic [AW-1:0] rt,
                      input bit rdy, input logic [IW-1:0] rd);
    out_t e;
    rst             = r;
    stall_req       = st;
    redirect_valid  = rv;
    redirect_target = rt;
    ready           = rdy;
    rdata           = rd;
    e = '0;
    if (r) begin
      boot_left   = BC;
      outstanding = 0;
      pend        = 0;
      held        = 0;
      ptgt        = '0;
      hval        = '0;
    end else if (boot_left > 0) begin
      boot_left--;
    end else if (held) begin
      if (rv) begin
        e.pc_en = 1; e.jump_en = 1; e.jt = rt; e.ifid = 1; e.idex = 1;
        held = 0;
      end else if (!st) begin
        e.fv = 1; e.inst = hval; e.pc_en = 1;
        held = 0;
      end
    end else if (outstanding) begin
      e.req = 1;
      if (rv) begin
        pend = 1; ptgt = rt; e.ifid = 1; e.idex = 1;
      end
      if (rdy) begin
        outstanding = 0;
        if (pend) begin
          e.pc_en = 1; e.jump_en = 1; e.jt = ptgt; e.ifid = 1;
          pend = 0;
        end else if (!st) begin
          e.fv = 1; e.inst = rd; e.pc_en = 1;
        end else begin
          held = 1; hval = rd;
        end
      end
    end else begin
      if (rv) begin
        e.pc_en = 1; e.jump_en = 1; e.jt = rt; e.ifid = 1; e.idex = 1;
      end else if (!st) begin
        e.req = 1;
        if (rdy) begin
          e.fv = 1; e.inst = rd; e.pc_en = 1;
        end else begin
          outstanding = 1;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output cycle against the queued prediction.
  always @(negedge clk) begin
    out_t e, act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = '{req: imem.imem_req, pc_en: pc_en, jump_en: jump_en, jt: jump_target,
              fv: fetch_valid, inst: inst_out, ifid: if_id_flush, idex: id_ex_flush};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got req=%b pc_en=%b jump_en=%b jt=%h fv=%b inst=%h ifid=%b idex=%b required req=%b pc_en=%b jump_en=%b jt=%h fv=%b inst=%h ifid=%b idex=%b",
                 cyc, act.req, act.pc_en, act.jump_en, act.jt, act.fv, act.inst, act.ifid, act.idex,
                 e.req, e.pc_en, e.jump_en, e.jt, e.fv, e.inst, e.ifid, e.idex);
      end
      cyc++;
    end
  end

  initial begin
    int p_rdy, p_st, p_rv;
    @(posedge clk);
    #1;
    // Reset/boot with single-cycle memory.
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 1, $urandom);
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1, $urandom);
    // Wait states.
    step(0, 0, 0, '0, 0, $urandom);
    step(0, 0, 0, '0, 0, $urandom);
    step(0, 0, 0, '0, 1, 32'h0000_0013);
    // Stall during wait, release two cycles after the response.
    step(0, 0, 0, '0, 0, $urandom);
    step(0, 1, 0, '0, 0, $urandom);
    step(0, 1, 0, '0, 1, 32'h00A0_0093);
    step(0, 1, 0, '0, 1, $urandom);
    step(0, 0, 0, '0, 1, $urandom);
    step(0, 0, 0, '0, 1, $urandom);
    // Redirect in FETCH.
    step(0, 0, 1, 32'hCAFE_BABC, 1, $urandom);
    step(0, 0, 0, '0, 1, $urandom);
    // Redirect in WAIT then PEND; youngest target wins.
    step(0, 0, 0, '0, 0, $urandom);
    step(0, 0, 1, 32'h0000_0100, 0, $urandom);
    step(0, 0, 1, 32'h0000_0200, 0, $urandom);
    step(0, 0, 0, '0, 1, $urandom);
    step(0, 0, 0, '0, 1, $urandom);
    // Redirect while holding a stalled instruction.
    step(0, 0, 0, '0, 0, $urandom);
    step(0, 1, 0, '0, 1, 32'h1111_2222);
    step(0, 1, 1, 32'h0000_4000, 1, $urandom);
    step(0, 0, 0, '0, 1, 32'h3333_4444);
    // Reset asserted mid-operation from WAIT, redirect during boot is ignored.
    step(0, 0, 0, '0, 0, $urandom);
    step(1, 0, 0, '0, 0, $urandom);
    step(1, 0, 1, 32'h0000_0040, 1, $urandom);
    step(0, 0, 1, 32'h0000_0080, 1, $urandom);
    step(0, 0, 1, 32'h0000_00C0, 1, $urandom);
    step(0, 0, 0, '0, 1, $urandom);
    // Randomized phases with different memory / hazard / redirect pressure.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin p_rdy = 100; p_st = 10; p_rv = 10; end
        1: begin p_rdy = 40;  p_st = 30; p_rv = 10; end
        2: begin p_rdy = 25;  p_st = 50; p_rv = 25; end
        default: begin p_rdy = 60; p_st = 20; p_rv = 40; end
      endcase
      for (int i = 0; i < 600; i++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 99) < p_st),
             ($urandom_range(0, 99) < p_rv),
             $urandom,
             ($urandom_range(0, 99) < p_rdy),
             $urandom);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d unchecked entries required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
